display_scan_controller: RTL and testbench

- Time-multiplexes NUM_DIGITS hex digits through a single shared BCD/hex-to-7-segment decoder onto a common-segment, per-digit-anode display.
- Holds the displayed value and sequences the digit index, the nibble presented to the decoder input, and the active-low digit enables.
- Inserts a dead-time between digits (anti-ghosting) and blanks leading zeros.
- New values are applied tear-free at frame boundaries, with an acknowledge pulse.

---
 rtl/display_scan_if.sv | 21 ++
 rtl/display_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// rtl/display_scan_if.sv - load/clear request and scan output bundle for the display scan controller
interface display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      clear;
  logic [3:0]                digit_code;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic                      ack;

  modport master (
    output load, value, clear,
    input  digit_code, digit_en, ack
  );

  modport slave (
    input  load, value, clear,
    output digit_code, digit_en, ack
  );
endinterface

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed hex display scanner with dead-time,
// leading-zero blanking and tear-free frame-boundary updates
module display_scan_controller #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD_CYCLES  = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic            clk,
  input  logic            rst,
  display_scan_if.slave   bus
);
  localparam int MAXC = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW   = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         display_q, display_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            code_q, code_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  ack_q, ack_d;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_run;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib[g] = display_q[4*g +: 4];
  end

  // A digit is blank when it and every more significant digit are zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (nib[i] == 4'h0);
      blank[i] = (BLANK_LEADING != 0) && zero_run;
    end
  end

  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    code_d    = code_q;
    en_d      = en_q;
    ack_d     = 1'b0;

    case (state_q)
      S_OFF: begin
        en_d = '1;
        if (bus.load) begin
          display_d = bus.value;
          idx_d     = '0;
          cnt_d     = '0;
          code_d    = bus.value[3:0];
          ack_d     = 1'b1;
          state_d   = S_GUARD;
        end
      end

      S_GUARD: begin
        if (bus.load) begin
          shadow_d  = bus.value;
          pending_d = 1'b1;
        end
        if (cnt_q == G_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
          en_d    = '1;
          if (!blank[idx_q]) en_d[idx_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_ON: begin
        if (cnt_q == R_LAST) begin
          state_d = S_GUARD;
          cnt_d   = '0;
          en_d    = '1;
          if (idx_q == I_LAST) begin
            // Frame boundary: a same-cycle load beats the older shadowed value.
            idx_d = '0;
            if (bus.load)      display_d = bus.value;
            else if (pending_q) display_d = shadow_q;
            ack_d     = bus.load | pending_q;
            pending_d = 1'b0;
            code_d    = display_d[3:0];
          end else begin
            idx_d  = idx_q + IW'(1);
            code_d = nib[idx_d];
            if (bus.load) begin
              shadow_d  = bus.value;
              pending_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
          end
        end
      end

      default: state_d = S_OFF;
    endcase

    if (bus.clear) begin
      state_d   = S_OFF;
      display_d = '0;
      pending_d = 1'b0;
      cnt_d     = '0;
      idx_d     = '0;
      code_d    = 4'h0;
      en_d      = '1;
      ack_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OFF;
      display_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      code_q    <= 4'h0;
      en_q      <= '1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      en_q      <= en_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.digit_code = code_q;
  assign bus.digit_en   = en_q;
  assign bus.ack        = ack_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
module tb_display_scan_controller;
  localparam int N = 4;
  localparam int R = 4;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scan_if #(.NUM_DIGITS(N)) bus ();
  display_scan_if #(.NUM_DIGITS(N)) bus_nb ();

  assign bus_nb.load  = bus.load;
  assign bus_nb.value = bus.value;
  assign bus_nb.clear = bus.clear;

  display_scan_controller #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G), .BLANK_LEADING(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  display_scan_controller #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G), .BLANK_LEADING(0)
  ) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] en_nb;
    logic [3:0] code;
    logic       ack;
    logic       chk_code;
  } exp_t;

  typedef struct packed {
    logic [15:0] value;
    logic [15:0] en_slots;
    logic [15:0] code_slots;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] en, input logic [3:0] en_nb, input logic [3:0] code,
                      input logic ack, input logic chk);
    exp_t e;
    e.en = en; e.en_nb = en_nb; e.code = code; e.ack = ack; e.chk_code = chk;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] lit(input int d);
    return ~(4'b0001 << d);
  endfunction

  task automatic push_frame_calc(input logic [15:0] v, input bit ack_first);
    logic [3:0] c;
    logic [3:0] en;
    for (int d = 0; d < N; d++) begin
      c  = v[4*d +: 4];
      en = ((d > 0) && ((v >> (4*d)) == 16'h0)) ? 4'hF : lit(d);
      for (int g = 0; g < G; g++) push(4'hF, 4'hF, c, ack_first && d == 0 && g == 0, 1'b1);
      for (int r = 0; r < R; r++) push(en, lit(d), c, 1'b0, 1'b1);
    end
  endtask

  task automatic push_frame_vec(input vec_t x, input bit ack_first);
    for (int d = 0; d < N; d++) begin
      for (int g = 0; g < G; g++)
        push(4'hF, 4'hF, x.code_slots[4*d +: 4], ack_first && d == 0 && g == 0, 1'b1);
      for (int r = 0; r < R; r++)
        push(x.en_slots[4*d +: 4], lit(d), x.code_slots[4*d +: 4], 1'b0, 1'b1);
    end
  endtask

  task automatic cyc(input logic ld, input logic [15:0] v, input logic clr);
    exp_t e;
    bus.load  = ld;
    bus.value = v;
    bus.clear = clr;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
    bus.clear = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_underflow: no expectation queued at %0t", $time);
    end else begin
      e = sb.pop_front();
      check("digit_en", bus.digit_en, e.en);
      check("digit_en_noblank", bus_nb.digit_en, e.en_nb);
      if (e.chk_code) begin
        check("digit_code", bus.digit_code, e.code);
        check("digit_code_noblank", bus_nb.digit_code, e.code);
      end
      check("ack", {3'b000, bus.ack}, {3'b000, e.ack});
      check("ack_noblank", {3'b000, bus_nb.ack}, {3'b000, e.ack});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      push(4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
      cyc(1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic clear_cyc();
    push(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
  endtask

  task automatic seq(input int n, input int la, input logic [15:0] va, input int lb,
                     input logic [15:0] vb, input int lc, input logic [15:0] vc);
    for (int j = 0; j < n; j++) begin
      if (j == la)      cyc(1'b1, va, 1'b0);
      else if (j == lb) cyc(1'b1, vb, 1'b0);
      else if (j == lc) cyc(1'b1, vc, 1'b0);
      else              cyc(1'b0, 16'h0, 1'b0);
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{value: 16'h1234, en_slots: 16'h7BDE, code_slots: 16'h1234};
    vecs[1] = '{value: 16'h0050, en_slots: 16'hFFDE, code_slots: 16'h0050};
    vecs[2] = '{value: 16'h0000, en_slots: 16'hFFFE, code_slots: 16'h0000};
    vecs[3] = '{value: 16'h0F00, en_slots: 16'hFBDE, code_slots: 16'h0F00};
    vecs[4] = '{value: 16'h8000, en_slots: 16'h7BDE, code_slots: 16'h8000};

    bus.load  = 1'b0;
    bus.value = 16'h0;
    bus.clear = 1'b0;

    for (int i = 0; i < 2; i++) begin
      push(4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
      cyc(1'b0, 16'h0, 1'b0);
    end
    rst = 1'b0;
    idle(100);

    for (int i = 0; i < 5; i++) begin
      clear_cyc();
      push_frame_vec(vecs[i], 1'b1);
      push_frame_vec(vecs[i], 1'b0);
      seq(2 * N * (G + R), 0, vecs[i].value, -1, 16'h0, -1, 16'h0);
    end

    // Two loads inside the digit-2 slot; only the last one lands, at the boundary.
    clear_cyc();
    push_frame_calc(16'h1234, 1'b1);
    push_frame_calc(16'h00FF, 1'b1);
    push_frame_calc(16'h00FF, 1'b0);
    seq(60, 0, 16'h1234, 12, 16'hABCD, 14, 16'h00FF);

    // A load on the boundary cycle beats an older pending value.
    clear_cyc();
    push_frame_calc(16'h1234, 1'b1);
    push_frame_calc(16'h9999, 1'b1);
    push_frame_calc(16'h9999, 1'b0);
    seq(60, 0, 16'h1234, 5, 16'h1111, 20, 16'h9999);

    // Clear wins over a same-cycle load while lit.
    push(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b0);
    end
    push_frame_calc(16'h0042, 1'b1);
    push_frame_calc(16'h0042, 1'b0);
    seq(23, 0, 16'h0042, -1, 16'h0, -1, 16'h0);
    sb.delete();

    // Asynchronous reset while digit 0 is lit, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_rst_en", bus.digit_en, 4'hF);
    check("async_rst_en_noblank", bus_nb.digit_en, 4'hF);
    check("async_rst_code", bus.digit_code, 4'h0);
    check("async_rst_ack", {3'b000, bus.ack}, 4'h0);
    #1 rst = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
